// File: rtl/image_pipe_unpack.sv
// image_pipe_unpack: splits DW_IN-bit packed words into PW-bit pixels, lane 0 first, one per beat.
// Define IMAGE_PIPE_UNPACK_STATS_EN to add the frame_cnt/pix_cnt output counters.
module image_pipe_unpack #(
   parameter int DW_IN = 32,
   parameter int PW    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DW_IN-1:0] is_data_in,
   input  logic             is_valid_in,
   input  logic             is_end_in,
   output logic             is_busy_out,
   output logic [PW-1:0]    im_data_out,
   output logic             im_valid_out,
   output logic             im_end_out,
   input  logic             im_busy_in
`ifdef IMAGE_PIPE_UNPACK_STATS_EN
   ,
   output logic [15:0]      frame_cnt,
   output logic [31:0]      pix_cnt
`endif
);
   localparam int N  = DW_IN / PW;
   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam logic [LW-1:0] LAST = LW'(N - 1);

   typedef enum logic {EMPTY, EMIT} state_t;

   state_t           state_q, state_d;
   logic [DW_IN-1:0] buf_q, buf_d;
   logic             end_q, end_d;
   logic [LW-1:0]    lane_q, lane_d;
   logic             buf_full, on_last, out_xfer, last_xfer, in_xfer;

   assign buf_full     = state_q == EMIT;
   assign on_last      = lane_q == LAST;
   assign out_xfer     = buf_full & ~im_busy_in;
   assign last_xfer    = out_xfer & on_last;
   // Draining the last lane frees the buffer in the same cycle, so a new word loads bubble-free.
   assign is_busy_out  = buf_full & ~last_xfer;
   assign in_xfer      = is_valid_in & ~is_busy_out;
   assign im_valid_out = buf_full;
   assign im_data_out  = buf_q[lane_q*PW +: PW];
   assign im_end_out   = buf_full & end_q & on_last;

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      end_d   = end_q;
      lane_d  = lane_q;
      if (in_xfer) begin
         state_d = EMIT;
         buf_d   = is_data_in;
         end_d   = is_end_in;
         lane_d  = '0;
      end else if (last_xfer) begin
         state_d = EMPTY;
         lane_d  = '0;
      end else if (out_xfer) begin
         lane_d  = lane_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         buf_q   <= '0;
         end_q   <= 1'b0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         end_q   <= end_d;
         lane_q  <= lane_d;
      end
   end

`ifdef IMAGE_PIPE_UNPACK_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [31:0] pix_cnt_q, pix_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      if (out_xfer) begin
         pix_cnt_d   = im_end_out ? '0 : pix_cnt_q + 1'b1;
         frame_cnt_d = im_end_out ? frame_cnt_q + 1'b1 : frame_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         pix_cnt_q   <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign pix_cnt   = pix_cnt_q;
`endif
endmodule

// File: tb/tb_image_pipe_unpack.sv
// tb_image_pipe_unpack: directed vector table, reset corner cases and a queue-scoreboard random run.
module tb_image_pipe_unpack;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] is_data_in = '0;
   logic        is_valid_in = 1'b0;
   logic        is_end_in = 1'b0;
   logic        is_busy_out;
   logic [7:0]  im_data_out;
   logic        im_valid_out;
   logic        im_end_out;
   logic        im_busy_in = 1'b0;
`ifdef IMAGE_PIPE_UNPACK_STATS_EN
   logic [15:0] frame_cnt;
   logic [31:0] pix_cnt;
`endif

   image_pipe_unpack #(.DW_IN(32), .PW(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .is_data_in(is_data_in), .is_valid_in(is_valid_in), .is_end_in(is_end_in),
      .is_busy_out(is_busy_out),
      .im_data_out(im_data_out), .im_valid_out(im_valid_out), .im_end_out(im_end_out),
      .im_busy_in(im_busy_in)
`ifdef IMAGE_PIPE_UNPACK_STATS_EN
      , .frame_cnt(frame_cnt), .pix_cnt(pix_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic        v, e;
      logic [31:0] d;
      logic        b;
      logic        xb, xv;
      logic [7:0]  xd;
      logic        xe;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic e, input logic [31:0] d, input logic b,
                      input logic xb, input logic xv, input logic [7:0] xd, input logic xe);
      vec_t t;
      t.v = v; t.e = e; t.d = d; t.b = b; t.xb = xb; t.xv = xv; t.xd = xd; t.xe = xe;
      tbl.push_back(t);
   endtask

   // Present a word and hold it until accepted; called and returns at posedge+1.
   task automatic push(input logic [31:0] d, input logic e);
      int n = 0;
      is_data_in = d; is_end_in = e; is_valid_in = 1'b1;
      #2;
      while (is_busy_out && n < 50) begin
         @(posedge clk); #3;
         n++;
      end
      if (n >= 50) chk("push_timeout", 1, 0);
      @(posedge clk); #1;
      is_valid_in = 1'b0;
   endtask

   logic [8:0]  expq[$];
   logic [8:0]  e9;
   logic [9:0]  prev_o;
   logic        prev_hold, in_acc;
   int          sent, cyc;

   initial begin
      // single word with end, then idle with a stray end flag
      add(1, 1, 32'h44332211, 0, 0, 0, 8'h00, 0);
      add(0, 0, 32'h0, 0, 1, 1, 8'h11, 0);
      add(0, 0, 32'h0, 0, 1, 1, 8'h22, 0);
      add(0, 0, 32'h0, 0, 1, 1, 8'h33, 0);
      add(0, 0, 32'h0, 0, 0, 1, 8'h44, 1);
      add(0, 1, 32'h0, 0, 0, 0, 8'h00, 0);
      // back-to-back three words, no bubble
      add(1, 0, 32'h03020100, 0, 0, 0, 8'h00, 0);
      for (int p = 0; p < 12; p++)
         add(p < 8, p >= 4 && p < 8, p < 4 ? 32'h07060504 : (p < 8 ? 32'h0B0A0908 : 32'h0),
             0, (p % 4) != 3, 1, 8'(p), p == 11);
      add(0, 0, 32'h0, 0, 0, 0, 8'h00, 0);
      // downstream stall at lane 2 with a new word waiting upstream
      add(1, 1, 32'h44332211, 0, 0, 0, 8'h00, 0);
      add(0, 0, 32'h0, 0, 1, 1, 8'h11, 0);
      add(0, 0, 32'h0, 0, 1, 1, 8'h22, 0);
      for (int k = 0; k < 5; k++) add(1, 0, 32'h88776655, 1, 1, 1, 8'h33, 0);
      add(1, 0, 32'h88776655, 0, 1, 1, 8'h33, 0);
      add(1, 0, 32'h88776655, 0, 0, 1, 8'h44, 1);
      add(0, 0, 32'h0, 0, 1, 1, 8'h55, 0);
      add(0, 0, 32'h0, 0, 1, 1, 8'h66, 0);
      add(0, 0, 32'h0, 0, 1, 1, 8'h77, 0);
      add(0, 1, 32'h0, 0, 0, 1, 8'h88, 0);
      add(0, 0, 32'h0, 0, 0, 0, 8'h00, 0);

      // reset held with valid input asserted
      is_valid_in = 1'b1; is_end_in = 1'b1; is_data_in = 32'hFFFFFFFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", im_valid_out, 0);
      chk("rst_end", im_end_out, 0);
      chk("rst_data", im_data_out, 0);
      chk("rst_busy", is_busy_out, 0);
      is_valid_in = 1'b0; is_end_in = 1'b0;
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         is_valid_in = tbl[i].v; is_end_in = tbl[i].e; is_data_in = tbl[i].d; im_busy_in = tbl[i].b;
         #2;
         chk($sformatf("vec%0d busy", i), is_busy_out, tbl[i].xb);
         chk($sformatf("vec%0d valid", i), im_valid_out, tbl[i].xv);
         chk($sformatf("vec%0d end", i), im_end_out, tbl[i].xe);
         if (tbl[i].xv) chk($sformatf("vec%0d data", i), im_data_out, tbl[i].xd);
         @(posedge clk); #1;
      end

      // asynchronous reset in the middle of a word
      is_valid_in = 1'b1; is_end_in = 1'b0; is_data_in = 32'h44332211; im_busy_in = 1'b0;
      @(posedge clk); #1;
      is_valid_in = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      chk("midrst_pre_data", im_data_out, 8'h33);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", im_valid_out, 0);
      chk("midrst_data", im_data_out, 0);
      chk("midrst_busy", is_busy_out, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      is_valid_in = 1'b1; is_data_in = 32'hDDCCBBAA;
      @(posedge clk); #1;
      is_valid_in = 1'b0;
      #1;
      chk("midrst_next_valid", im_valid_out, 1);
      chk("midrst_next_data", im_data_out, 8'hAA);
      repeat (4) @(posedge clk);
      #1;

      // random valid/busy against a pixel queue
      sent = 0; cyc = 0; prev_hold = 1'b0; prev_o = '0;
      while ((sent < 1000 || expq.size() != 0 || is_valid_in) && cyc < 20000) begin
         if (!is_valid_in && sent < 1000 && $urandom_range(9) < 7) begin
            is_data_in  = $urandom;
            is_end_in   = (sent == 999) || ($urandom_range(3) == 0);
            is_valid_in = 1'b1;
         end
         im_busy_in = $urandom_range(9) < 3;
         #2;
         if (prev_hold) chk("rand_hold", {im_valid_out, im_end_out, im_data_out}, prev_o);
         if (im_valid_out && !im_busy_in) begin
            if (expq.size() == 0) chk("rand_extra", 1, 0);
            else begin
               e9 = expq.pop_front();
               chk("rand_pix", {im_end_out, im_data_out}, e9);
            end
         end
         in_acc = is_valid_in && !is_busy_out;
         if (in_acc) begin
            for (int l = 0; l < 4; l++) expq.push_back({is_end_in && l == 3, is_data_in[l*8 +: 8]});
            sent++;
         end
         prev_hold = im_valid_out && im_busy_in;
         prev_o = {im_valid_out, im_end_out, im_data_out};
         @(posedge clk); #1;
         cyc++;
         if (in_acc) begin
            is_valid_in = 1'b0; is_end_in = 1'($urandom); is_data_in = $urandom;
         end
      end
      chk("rand_done", {sent == 1000, expq.size() == 0}, 2'b11);
      im_busy_in = 1'b0; is_end_in = 1'b0;

`ifdef IMAGE_PIPE_UNPACK_STATS_EN
      rst_n = 1'b0;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("stats_rst_frame", frame_cnt, 0);
      chk("stats_rst_pix", pix_cnt, 0);
      for (int f = 0; f < 3; f++) begin
         push(32'h11223344 + f, 1'b0);
         push(32'h55667788 + f, 1'b1);
      end
      repeat (6) @(posedge clk);
      #1;
      chk("stats_frame3", frame_cnt, 3);
      chk("stats_pix0", pix_cnt, 0);
      push(32'hA1A2A3A4, 1'b0);
      push(32'hB1B2B3B4, 1'b1);
      @(posedge clk); #1;
      im_busy_in = 1'b1;
      #1;
      chk("stats_pix5", pix_cnt, 5);
      chk("stats_frame_mid", frame_cnt, 3);
      im_busy_in = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/image_pipe_unpack.md
Name: image_pipe_unpack

Overview:
- Downstream stage of the image pipe's packed-word output.
- Consumes packed DW_IN-bit words, each holding N = DW_IN/PW pixels, on the valid/end/busy protocol.
- Re-emits the same stream one pixel per beat on the same protocol, asserting end on the last pixel of the frame.
- Zero-bubble throughput: one pixel per clk while the downstream stage is not busy.

Parameters:
- DW_IN, 32, packed input word width; must be an integer multiple of PW.
- PW, 8, pixel width; this is also the output data width.
- N (localparam), DW_IN/PW, pixels per word.
- LW (localparam), $clog2(N) with a minimum of 1, lane counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous assert, active-low; deassertion synchronised externally.
- is_data_in  in  DW_IN  packed input word.
- is_valid_in  in  1  input word valid.
- is_end_in  in  1  input word is the last word of the frame.
- is_busy_out  out  1  backpressure to upstream.
- im_data_out  out  PW  output pixel.
- im_valid_out  out  1  output pixel valid.
- im_end_out  out  1  last pixel of the frame.
- im_busy_in  in  1  backpressure from downstream.

Behaviour:
- Interface: single clock domain, clock port clk, reset port rst_n. Reset is asynchronous and active-low.
- Handshake, both sides: a transfer occurs on a posedge where valid=1 and busy=0.
  - While busy=1, the sender holds data, valid and end stable.
  - Valid never depends on busy.
- State is a hold register buf[DW_IN] plus flags buf_full and buf_end, and lane[LW]. These form two states:
  - EMPTY: buf_full=0.
  - EMIT: buf_full=1.
- Output decode (combinational from registers only):
  - im_valid_out = buf_full.
  - im_data_out = buf[lane*PW +: PW]. Lane 0 is bits [PW-1:0] and is emitted first.
  - im_end_out = buf_full & buf_end & (lane==N-1).
- Output transfer: out_xfer = buf_full & ~im_busy_in.
- Last-lane drain: last_xfer = out_xfer & (lane==N-1).
- Backpressure: is_busy_out = buf_full & ~last_xfer. This is combinational from im_busy_in and is the only input-to-output path.
- Load: in_xfer = is_valid_in & ~is_busy_out. On in_xfer, buf <= is_data_in, buf_end <= is_end_in, lane <= 0, buf_full <= 1.
- Transitions:
  - EMPTY -> EMIT on in_xfer.
  - EMIT: on out_xfer with lane<N-1, lane increments.
  - EMIT, on last_xfer with no in_xfer in the same cycle -> EMPTY (buf_full <= 0, lane <= 0).
  - EMIT, on last_xfer with in_xfer in the same cycle: stay in EMIT and load the new word. This simultaneous event gives back-to-back words with no bubble.
- Latency: the first pixel of a word is valid on the cycle after in_xfer.
- Steady-state throughput is one word per N cycles. Upstream sees busy for N-1 of every N cycles.
- Backpressure mid-word: lane and buf hold, and the output stays stable.
- is_end_in with is_valid_in=0 is ignored.
- Data passes unmodified. No arithmetic beyond the lane increment; the lane wraps only via the reload to 0.
- Reset values:
  - buf_full=0, buf_end=0, lane=0, buf=0.
  - Hence im_valid_out=0, im_end_out=0, im_data_out=0, is_busy_out=0.
- Reset mid-word or mid-frame discards the buffered word immediately (async). After reset release, the next accepted word is treated as fresh.
- N=1 (DW_IN==PW) must work as a one-deep registered pass-through, with is_busy_out = buf_full & im_busy_in.

Optional Feature:
- Macro: IMAGE_PIPE_UNPACK_STATS_EN.
- Defined: adds output frame_cnt [15:0] and output pix_cnt [31:0], both reset to 0.
  - pix_cnt increments on every out_xfer.
  - pix_cnt clears to 0 on the out_xfer that carries im_end_out=1.
  - frame_cnt increments on that same transfer and wraps 0xFFFF -> 0.
  - The counter ports exist only when the macro is defined.
- Not defined: no counter logic and no extra ports. The datapath is identical in both builds.

Test Plan:
- Reset: rst_n=0 with is_valid_in=1 -> all outputs 0. After release, word 0x44332211 with end=1 -> pixels 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; im_end_out=1 only with 0x44.
- Back-to-back: 3 words 0x03020100, 0x07060504, 0x0B0A0908 (end on the last), im_busy_in=0 -> 12 pixels 0x00..0x0B on 12 consecutive cycles with no gap. is_busy_out pattern is 0,1,1,1 repeating; end only on 0x0B.
- Downstream stall: im_busy_in=1 for 5 cycles while lane=2 -> im_data_out holds 0x33 and is_busy_out=1 for all 5 cycles. Emission resumes with 0x33 then 0x44; no pixel is lost or duplicated.
- Reset mid-word: assert rst_n=0 after pixel 0x22 -> im_valid_out drops asynchronously. Next word 0xDDCCBBAA -> first pixel 0xAA.
- Random valid and busy over 1000 words vs. a scoreboard model: pixel order and end placement match exactly, and the hold rules on both sides are never violated.
- STATS build: 3 frames of 2 words each -> frame_cnt=3 and pix_cnt=0 at the end. Mid-frame after 5 pixel transfers -> pix_cnt=5.
